muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 116 +++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM state type.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_UREM  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// Single combinational iteration: shift-add multiply step, or restoring-divide step when
// MULDIV_DIV_EN is defined (without it the divide path and its select input do not exist).
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
`endif

    always_comb begin
        // Multiply: hi accumulates partial products, lo shifts the multiplier out LSB first.
        sum    = lo[0] ? ({1'b0, hi} + {1'b0, m}) : {1'b0, hi};
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            hi_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ~diff[WIDTH]};
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with register-file writeback, one bit per cycle.
// MULDIV_DIV_EN enables UDIV/UREM; without it those ops keep the timing and write zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       wa,
    output logic             busy,
    output logic             wb_we,
    output logic [3:0]       wb_wa,
    output logic [WIDTH-1:0] wb_wd
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [3:0]       wa_r;
    logic [WIDTH-1:0] hi, lo, m;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH-1:0] res;
    logic             last;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .is_div (op_r[1]),
`endif
        .hi     (hi),
        .lo     (lo),
        .m      (m),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    assign last = (cnt == CW'(1));

    always_comb begin
        case (op_r)
            OP_MUL:   res = lo_nxt;
            OP_UMULH: res = hi_nxt;
`ifdef MULDIV_DIV_EN
            OP_UDIV:  res = lo_nxt;
            OP_UREM:  res = hi_nxt;
`endif
            default:  res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        wb_we     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                wb_we     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_r  <= '0;
            wa_r  <= '0;
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            wb_wa <= '0;
            wb_wd <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_r <= op;
                    wa_r <= wa;
                    hi   <= '0;
                    lo   <= op[1] ? a : b;
                    m    <= op[1] ? b : a;
                    cnt  <= CW'(WIDTH);
                end
                S_RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt - CW'(1);
                    // Result is captured on the final iteration so it is stable throughout DONE.
                    if (last) begin
                        wb_wa <= wa_r;
                        wb_wd <= res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases, randomized ops
// against an arithmetic reference model, busy-drop, reset abort and back-to-back issue.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  wa;
    logic        busy, wb_we;
    logic [3:0]  wb_wa;
    logic [31:0] wb_wd;

    int tests  = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .wa(wa),
        .busy(busy), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        case (o)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
`ifdef MULDIV_DIV_EN
            2'b10: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'b11: return (y == 0) ? x : x % y;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Issues one request from IDLE and scrambles the inputs while it is in flight.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] w, output int lat, output logic [3:0] owa,
                         output logic [31:0] owd, output logic bsy_run, output logic bsy_after,
                         output logic [31:0] wd_after);
        op = o; a = x; b = y; wa = w; start = 1'b1;
        lat = 0; owa = '0; owd = '0; bsy_run = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                start   = 1'b0;
                bsy_run = busy;
            end
            op = 2'($urandom); a = $urandom; b = $urandom; wa = 4'($urandom);
            if (wb_we) begin
                lat = k; owa = wb_wa; owd = wb_wd;
                break;
            end
        end
        tick();
        bsy_after = busy;
        wd_after  = wb_wd;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; wa = '0;
        repeat (3) tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (wb_we !== 1'b0)  begin errors++; $display("FAIL reset_we got %0b want 0", wb_we); end
        tests++; if (wb_wa !== 4'h0)  begin errors++; $display("FAIL reset_wa got %0h want 0", wb_wa); end
        tests++; if (wb_wd !== 32'h0) begin errors++; $display("FAIL reset_wd got %0h want 0", wb_wd); end
    endtask

    task automatic test_directed();
        logic [1:0]  dop [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
        logic [31:0] da  [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'd0};
        logic [31:0] db  [8] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0, 32'hDEAD_BEEF};
`ifdef MULDIV_DIV_EN
        logic [31:0] exp [8] = '{32'd42, 32'h1, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'd0};
`else
        logic [31:0] exp [8] = '{32'd42, 32'h1, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
        int lat; logic [3:0] owa; logic [31:0] owd, wd_after; logic br, ba;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] w;
            w = (i == 0) ? 4'd3 : 4'(i + 8);
            do_op(dop[i], da[i], db[i], w, lat, owa, owd, br, ba, wd_after);
            tests++; if (lat != 33)      begin errors++; $display("FAIL dir%0d_latency got %0d want 33", i, lat); end
            tests++; if (owa !== w)      begin errors++; $display("FAIL dir%0d_wa got %0d want %0d", i, owa, w); end
            tests++; if (owd !== exp[i]) begin errors++; $display("FAIL dir%0d_wd got %h want %h", i, owd, exp[i]); end
            tests++; if (br !== 1'b1)    begin errors++; $display("FAIL dir%0d_busy_run got %0b want 1", i, br); end
            tests++; if (ba !== 1'b0)    begin errors++; $display("FAIL dir%0d_busy_after got %0b want 0", i, ba); end
            tests++; if (wd_after !== exp[i]) begin errors++; $display("FAIL dir%0d_wd_hold got %h want %h", i, wd_after, exp[i]); end
        end
    endtask

    task automatic test_random();
        int lat; logic [3:0] owa; logic [31:0] owd, wd_after, exp, x, y; logic br, ba;
        logic [1:0] o; logic [3:0] w;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); x = $urandom; w = 4'($urandom);
            y = (i % 8 == 0) ? 32'h0 : ((i % 3 == 0) ? ($urandom >> $urandom_range(31, 0)) : $urandom);
            exp = model(o, x, y);
            do_op(o, x, y, w, lat, owa, owd, br, ba, wd_after);
            tests++; if (lat != 33) begin errors++; $display("FAIL rnd%0d_latency got %0d want 33", i, lat); end
            tests++; if (owa !== w) begin errors++; $display("FAIL rnd%0d_wa got %0d want %0d", i, owa, w); end
            tests++;
            if (owd !== exp) begin
                errors++;
                $display("FAIL rnd%0d_wd op=%0d a=%h b=%h got %h want %h", i, o, x, y, owd, exp);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0; int first = 0; logic [3:0] fwa = '0; logic [31:0] fwd = '0;
        op = 2'b00; a = 32'd5; b = 32'd5; wa = 4'd1; start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            start = (k == 10);
            if (k == 10) begin op = 2'b00; a = 32'd9; b = 32'd9; wa = 4'd2; end
            if (wb_we) begin
                pulses++;
                if (pulses == 1) begin first = k; fwa = wb_wa; fwd = wb_wd; end
            end
        end
        tests++; if (pulses != 1)   begin errors++; $display("FAIL drop_pulses got %0d want 1", pulses); end
        tests++; if (first != 33)   begin errors++; $display("FAIL drop_latency got %0d want 33", first); end
        tests++; if (fwa !== 4'd1)  begin errors++; $display("FAIL drop_wa got %0d want 1", fwa); end
        tests++; if (fwd !== 32'd25) begin errors++; $display("FAIL drop_wd got %0d want 25", fwd); end
    endtask

    task automatic test_reset_abort();
        int pulses = 0; int lat; logic [3:0] owa; logic [31:0] owd, wd_after; logic br, ba;
        op = 2'b00; a = 32'd5; b = 32'd5; wa = 4'd6; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = 1'b0;
            if (wb_we) pulses++;
            if (k == 15) reset = 1'b1;
            if (k == 16) begin
                reset = 1'b0;
                tests++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
            end
        end
        tests++; if (pulses != 0) begin errors++; $display("FAIL abort_no_we got %0d want 0", pulses); end
        do_op(2'b00, 32'd3, 32'd4, 4'd5, lat, owa, owd, br, ba, wd_after);
        tests++; if (lat != 33)     begin errors++; $display("FAIL abort_next_latency got %0d want 33", lat); end
        tests++; if (owd !== 32'd12) begin errors++; $display("FAIL abort_next_wd got %0d want 12", owd); end
        tests++; if (owa !== 4'd5)  begin errors++; $display("FAIL abort_next_wa got %0d want 5", owa); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] owa; logic [31:0] owd, wd_after, exp; logic br, ba;
        logic [1:0] o; logic [31:0] x, y;
        for (int i = 0; i < 4; i++) begin
            o = 2'($urandom); x = $urandom; y = $urandom_range(1000, 1);
            exp = model(o, x, y);
            do_op(o, x, y, 4'(i), lat, owa, owd, br, ba, wd_after);
            tests++; if (lat != 33) begin errors++; $display("FAIL b2b%0d_latency got %0d want 33", i, lat); end
            tests++; if (owd !== exp) begin errors++; $display("FAIL b2b%0d_wd got %h want %h", i, owd, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
